// File: rtl/kd_internal_node_tree.sv
// Node storage for a depth-6 KD tree, loaded serially in BFS order, with two
// independent 6-stage query pipelines that each route a patch to one of 64 leaves.
module kd_internal_node_tree #(
  parameter int INTERNAL_WIDTH = 22,
  parameter int PATCH_WIDTH    = 55,
  parameter int ADDRESS_WIDTH  = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      fsm_enable,
  input  logic                      sender_enable,
  input  logic [INTERNAL_WIDTH-1:0] sender_data,
  input  logic                      patch_en,
  input  logic                      patch_two_en,
  input  logic [PATCH_WIDTH-1:0]    patch_in,
  input  logic [PATCH_WIDTH-1:0]    patch_in_two,
  output logic [ADDRESS_WIDTH-1:0]  leaf_index,
  output logic [ADDRESS_WIDTH-1:0]  leaf_index_two,
  output logic                      receiver_en,
  output logic                      receiver_two_en
);

  localparam int NODES = 63;
  localparam int DEPTH = 6;

  logic [INTERNAL_WIDTH-1:0] r_node [NODES];
  logic [5:0]                r_wptr;
  logic                      w_wr;

  // Loading stops for good at 63 words; only reset reopens the table.
  assign w_wr = fsm_enable & sender_enable & (r_wptr != 6'd63);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr <= '0;
      for (int i = 0; i < NODES; i++) r_node[i] <= '0;
    end else if (w_wr) begin
      r_node[r_wptr] <= sender_data;
      r_wptr         <= r_wptr + 6'd1;
    end
  end

  // Split dims 5..7 fall back to element 0; element 0 sits in the patch MSBs.
  function automatic logic go_right(input logic [PATCH_WIDTH-1:0] p,
                                    input logic [2:0] dim,
                                    input logic signed [10:0] med);
    logic signed [10:0] elem;
    case (dim)
      3'd1:    elem = p[43:33];
      3'd2:    elem = p[32:22];
      3'd3:    elem = p[21:11];
      3'd4:    elem = p[10:0];
      default: elem = p[54:44];
    endcase
    return (elem >= med);
  endfunction

  logic [1:0]             w_q_en;
  logic [PATCH_WIDTH-1:0] w_q_patch [2];

  assign w_q_en       = {patch_two_en, patch_en};
  assign w_q_patch[0] = patch_in;
  assign w_q_patch[1] = patch_in_two;

  for (genvar g = 0; g < 2; g++) begin : g_lane
    logic [DEPTH-1:0]         r_vld;
    logic [5:0]               r_idx [DEPTH];
    logic [PATCH_WIDTH-1:0]   r_pat [DEPTH];
    logic [DEPTH-1:0]         w_right;
    logic [5:0]               w_last_off;
    logic [ADDRESS_WIDTH-1:0] r_leaf;
    logic                     r_rx;

    // Reads see the table before any write landing on the same edge.
    always_comb begin
      w_right = '0;
      for (int s = 0; s < DEPTH; s++)
        w_right[s] = go_right(r_pat[s], r_node[r_idx[s]][2:0], r_node[r_idx[s]][21:11]);
    end

    assign w_last_off = r_idx[DEPTH-1] - 6'd31;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_vld  <= '0;
        r_leaf <= '0;
        r_rx   <= 1'b0;
        for (int s = 0; s < DEPTH; s++) begin
          r_idx[s] <= '0;
          r_pat[s] <= '0;
        end
      end else begin
        r_vld    <= {r_vld[DEPTH-2:0], w_q_en[g]};
        r_idx[0] <= '0;
        r_pat[0] <= w_q_patch[g];
        for (int s = 1; s < DEPTH; s++) begin
          r_idx[s] <= {r_idx[s-1][4:0], 1'b0} + 6'd1 + {5'd0, w_right[s-1]};
          r_pat[s] <= r_pat[s-1];
        end
        r_rx <= r_vld[DEPTH-1];
        // Leaf = 2n+1+right-63 for last-level node n, i.e. {n-31, right}.
        if (r_vld[DEPTH-1])
          r_leaf <= {{(ADDRESS_WIDTH-6){1'b0}}, w_last_off[4:0], w_right[DEPTH-1]};
      end
    end
  end

  assign leaf_index      = g_lane[0].r_leaf;
  assign receiver_en     = g_lane[0].r_rx;
  assign leaf_index_two  = g_lane[1].r_leaf;
  assign receiver_two_en = g_lane[1].r_rx;

endmodule

// File: tb/tb_kd_internal_node_tree.sv
// Bench for kd_internal_node_tree: vector tables and hand sequences feed a
// per-lane scoreboard that checks leaf value, arrival cycle and output hold.
module tb_kd_internal_node_tree;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        fsm_enable = 1'b0, sender_enable = 1'b0;
  logic [21:0] sender_data = '0;
  logic        patch_en = 1'b0, patch_two_en = 1'b0;
  logic [54:0] patch_in = '0, patch_in_two = '0;
  logic [7:0]  leaf_index, leaf_index_two;
  logic        receiver_en, receiver_two_en;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;
  int last1 = 0;
  int last2 = 0;

  typedef struct { int leaf; int due; } exp_t;
  typedef struct { bit lane; logic [54:0] patch; int leaf; } vec_t;

  exp_t        q1[$];
  exp_t        q2[$];
  logic [21:0] tree [63];

  kd_internal_node_tree #(.INTERNAL_WIDTH(22), .PATCH_WIDTH(55), .ADDRESS_WIDTH(8)) dut (
    .clk(clk), .rst(rst), .fsm_enable(fsm_enable), .sender_enable(sender_enable),
    .sender_data(sender_data), .patch_en(patch_en), .patch_two_en(patch_two_en),
    .patch_in(patch_in), .patch_in_two(patch_in_two), .leaf_index(leaf_index),
    .leaf_index_two(leaf_index_two), .receiver_en(receiver_en),
    .receiver_two_en(receiver_two_en)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int req);
    n_vec++;
    if (act != req) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      last1 = 0;
      last2 = 0;
    end else begin
      if (receiver_en) begin
        if (q1.size() == 0) check("lane1 unexpected pulse", 1, 0);
        else begin
          e = q1.pop_front();
          check("lane1 leaf", int'(leaf_index), e.leaf);
          check("lane1 latency", cyc, e.due);
          last1 = e.leaf;
        end
      end else check("lane1 hold", int'(leaf_index), last1);
      if (receiver_two_en) begin
        if (q2.size() == 0) check("lane2 unexpected pulse", 1, 0);
        else begin
          e = q2.pop_front();
          check("lane2 leaf", int'(leaf_index_two), e.leaf);
          check("lane2 latency", cyc, e.due);
          last2 = e.leaf;
        end
      end else check("lane2 hold", int'(leaf_index_two), last2);
    end
  end

  function automatic logic [54:0] mkp(input int a, input int b, input int c, input int d, input int e);
    return {a[10:0], b[10:0], c[10:0], d[10:0], e[10:0]};
  endfunction

  function automatic logic [54:0] rndp();
    int v [5];
    for (int k = 0; k < 5; k++) v[k] = int'($urandom_range(300)) - 150;
    return mkp(v[0], v[1], v[2], v[3], v[4]);
  endfunction

  // Mixed dims including the 5..7 fallback, junk in bits [10:3].
  function automatic logic [21:0] node_word(input int n);
    int mi, g, d;
    mi = ((n * 37) % 200) - 100;
    g  = n * 13;
    d  = n % 8;
    return {mi[10:0], g[7:0], d[2:0]};
  endfunction

  function automatic int model_leaf(input logic [54:0] p, input logic [21:0] t [63]);
    int n, k;
    logic [21:0]        w;
    logic signed [10:0] el, md;
    n = 0;
    for (int lvl = 0; lvl < 6; lvl++) begin
      w  = t[n];
      k  = (w[2:0] > 3'd4) ? 0 : int'(w[2:0]);
      el = p[54 - 11*k -: 11];
      md = w[21:11];
      n  = (el < md) ? 2*n + 1 : 2*n + 2;
    end
    return n - 63;
  endfunction

  task automatic send(input bit e1, input logic [54:0] p1, input int x1,
                      input bit e2, input logic [54:0] p2, input int x2);
    exp_t e;
    @(negedge clk);
    patch_en = e1; patch_in = p1; patch_two_en = e2; patch_in_two = p2;
    if (e1) begin e.leaf = x1; e.due = cyc + 7; q1.push_back(e); end
    if (e2) begin e.leaf = x2; e.due = cyc + 7; q2.push_back(e); end
  endtask

  task automatic idle(input int n);
    @(negedge clk);
    patch_en = 1'b0; patch_two_en = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic load(input bit fen, input logic [21:0] w);
    @(negedge clk);
    fsm_enable = fen; sender_enable = 1'b1; sender_data = w;
  endtask

  task automatic load_end();
    @(negedge clk);
    fsm_enable = 1'b0; sender_enable = 1'b0;
  endtask

  task automatic apply(input vec_t v);
    send(!v.lane, v.patch, v.leaf, v.lane, v.patch, v.leaf);
  endtask

  initial begin
    vec_t uni [5];
    vec_t vb  [10];
    logic [54:0] p1, p2;
    bit e1, e2;

    repeat (3) @(negedge clk);
    check("reset leaf_index", int'(leaf_index), 0);
    check("reset leaf_index_two", int'(leaf_index_two), 0);
    check("reset receiver_en", int'(receiver_en), 0);
    check("reset receiver_two_en", int'(receiver_two_en), 0);
    #2 rst = 1'b0;

    // Uniform tree: dim 0 (junk upper dim bits), median 0.
    for (int i = 0; i < 63; i++) load(1'b1, {11'd0, 8'h5A, 3'd0});
    load_end();

    uni[0] = '{1'b0, mkp(-1, 7, 7, 7, 7), 0};
    uni[1] = '{1'b0, mkp(0, -5, -5, -5, -5), 63};
    uni[2] = '{1'b1, mkp(5, -9, -9, -9, -9), 63};
    uni[3] = '{1'b1, mkp(-1024, 1023, 1023, 1023, 1023), 0};
    uni[4] = '{1'b0, mkp(1023, -1024, -1024, -1024, -1024), 63};
    for (int i = 0; i < 5; i++) begin
      apply(uni[i]);
      idle(8);
    end
    send(1'b1, mkp(0, 1, 2, 3, 4), 63, 1'b1, mkp(5, 0, 0, 0, 0), 63);
    idle(8);

    // Reset at T+3 of an in-flight query: outputs clear at once, no pulse follows.
    @(negedge clk);
    patch_en = 1'b1; patch_in = mkp(-1, 0, 0, 0, 0);
    @(posedge clk);
    #1 patch_en = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check("midreset leaf_index", int'(leaf_index), 0);
    check("midreset leaf_index_two", int'(leaf_index_two), 0);
    check("midreset receiver_en", int'(receiver_en), 0);
    check("midreset receiver_two_en", int'(receiver_two_en), 0);
    repeat (2) @(negedge clk);
    #2 rst = 1'b0;
    repeat (10) @(negedge clk);

    // Mixed tree with gated words before and inside the load and 7 overflow words.
    for (int i = 0; i < 63; i++) tree[i] = node_word(i);
    for (int i = 0; i < 5; i++) load(1'b0, ~node_word(i));
    for (int i = 0; i < 63; i++) begin
      if (i == 20) for (int j = 0; j < 3; j++) load(1'b0, ~tree[j]);
      load(1'b1, tree[i]);
    end
    for (int i = 0; i < 7; i++) load(1'b1, ~tree[i]);
    load_end();

    vb[0] = '{1'b0, mkp(251, -26, -1, -88, 79), 0};
    vb[1] = '{1'b1, mkp(279, -18, -55, -22, 18), 0};
    vb[2] = '{1'b0, mkp(-72, -213, 201, 45, 235), 0};
    vb[3] = '{1'b1, mkp(-245, -199, 45, 58, 177), 0};
    vb[4] = '{1'b0, mkp(-50, -64, -298, 245, -141), 0};
    for (int i = 5; i < 10; i++) vb[i] = '{bit'(i % 2), rndp(), 0};
    for (int i = 0; i < 10; i++) vb[i].leaf = model_leaf(vb[i].patch, tree);
    for (int i = 0; i < 10; i++) apply(vb[i]);
    idle(8);

    // Three consecutive lane-1 queries return on consecutive cycles.
    for (int i = 2; i < 5; i++) send(1'b1, vb[i].patch, vb[i].leaf, 1'b0, '0, 0);
    idle(8);

    // Random two-lane traffic.
    for (int i = 0; i < 40; i++) begin
      e1 = 1'($urandom_range(1));
      e2 = 1'($urandom_range(1));
      p1 = rndp();
      p2 = rndp();
      send(e1, p1, model_leaf(p1, tree), e2, p2, model_leaf(p2, tree));
    end
    idle(10);

    check("lane1 drained", q1.size(), 0);
    check("lane2 drained", q2.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/kd_internal_node_tree.md
Name: kd_internal_node_tree

Overview:
- Stores the 63 internal nodes (split dimension, median) of a depth-6 KD tree and routes query patches to one of 64 leaves.
- Loaded serially from the aggregator output stream (SyncFIFO feeds the aggregator, which feeds this block).
- Two independent query lanes share the node storage. Each lane is a 6-stage pipeline, one tree level per stage, and returns a leaf index to the leaf/candidate stage.

Parameters:
- INTERNAL_WIDTH, 22: node word width. Bits [10:0] = split dimension, bits [21:11] = signed median.
- PATCH_WIDTH, 55: patch width, 5 signed 11-bit elements.
- ADDRESS_WIDTH, 8: leaf index output width.

Ports:
- clk  in  1  single clock, all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- fsm_enable  in  1  load phase enable; node writes are accepted only when high.
- sender_enable  in  1  node word valid (aggregator receiver_enq).
- sender_data  in  INTERNAL_WIDTH  node word.
- patch_en  in  1  lane-1 query valid.
- patch_two_en  in  1  lane-2 query valid.
- patch_in  in  PATCH_WIDTH  lane-1 patch.
- patch_in_two  in  PATCH_WIDTH  lane-2 patch.
- leaf_index  out  ADDRESS_WIDTH  lane-1 result.
- leaf_index_two  out  ADDRESS_WIDTH  lane-2 result.
- receiver_en  out  1  lane-1 result valid pulse.
- receiver_two_en  out  1  lane-2 result valid pulse.

Behaviour:
- Reset (asynchronous, active-high):
  - write pointer = 0; all node words = 0; all pipeline valids = 0.
  - leaf_index = leaf_index_two = 0; receiver_en = receiver_two_en = 0.
- Loading:
  - On a clock edge with fsm_enable=1 and sender_enable=1, node[wptr] <= sender_data and wptr increments.
  - Nodes are in heap/BFS order: node 0 is the root; children of node n are 2n+1 (left) and 2n+2 (right).
  - Once wptr = 63, further writes are ignored until reset. There is no wrap.
  - fsm_enable=0 blocks writes; wptr holds its value.
- Patch layout: element k (k = 0..4) = patch[54-11k : 44-11k], two's complement. Element 0 is the MSBs.
- Split dimension = sender_data[2:0]. Values 5 to 7 select element 0. Bits [10:3] are ignored.
- Traversal, per lane:
  - Stage L (L = 0..5) holds node n at level L.
  - If patch[dim(n)] < median(n) (signed compare), go left to 2n+1; otherwise (greater or equal) go right to 2n+2.
  - After 6 decisions, leaf = n_final − 63, in the range 0..63, zero-extended to ADDRESS_WIDTH.
- Latency and throughput:
  - A query sampled with patch_en=1 at edge T gives receiver_en=1 and a valid leaf_index at edge T+6.
  - receiver_en is high for exactly one cycle per query.
  - Fully pipelined: one new query per lane per cycle. Back-to-back queries return in order on consecutive cycles.
  - Patch data is registered into the pipeline alongside the node index.
- Lanes are fully independent:
  - Both lanes may be enabled on the same cycle and both return 6 cycles later.
  - An idle lane leaves its outputs untouched.
- leaf_index and leaf_index_two hold their last value when no new result arrives.
- Queries issued during loading use the current node contents at each stage. No stall and no error.
- A simultaneous write to a node and a stage read of that node returns the old contents.
- Reset mid-query flushes all in-flight queries. No valid pulse follows the reset.

Test Plan:
- Uniform tree (63 nodes: dim 0, median 0), lane 1 patch with element0 = −1 → leaf_index = 0, receiver_en high at exactly T+6.
- Same tree, element0 = 0 (tie) → 63. Element0 = 5 on lane 2, in the same cycle as lane 1 → both lanes report 63 at T+6.
- Production node file loaded through SyncFIFO and aggregator (2 × 11-bit words per node):
  - lane 1 [251,−26,−1,−88,79] → 59.
  - lane 2 [279,−18,−55,−22,18] → 60.
  - lane 1 [−72,−213,201,45,235] → 22.
  - lane 2 [−245,−199,45,58,177] → 5.
  - lane 1 [−50,−64,−298,245,−141] → 24.
- Pipelined: three lane-1 queries on consecutive cycles → results 22, 5, 24 at T+6, T+7, T+8, with receiver_en high for 3 cycles.
- Load 70 words, or words with fsm_enable=0 → words past 63 and gated words are not stored; traversal results are unchanged.
- Assert rst at T+3 of an in-flight query → outputs go to 0 immediately, and no receiver_en pulse follows.
